interrupt_arbiter: RTL and testbench
====================================

# interrupt_arbiter

Parametrised trap arbiter for the pipelined RISC-V core: latches up to NSRC interrupt sources into pending bits, applies per-source and global enables, and waits for a safe pipeline point. It then issues a registered one-cycle trap request with cause, return PC and exception/interrupt flag, and holds off further traps until the CSR unit acknowledges. W-stage exceptions always take precedence over interrupts. Sits between the CSR file (mie/mip) and the fetch redirect logic.

## Interface
- NSRC, 8, number of interrupt sources; index 0 is highest priority
- EDGE_MASK, '0 (NSRC bits), bit i = 1 makes source i edge-triggered, 0 makes it level-triggered
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- src_i  in  NSRC  raw interrupt lines
- src_en  in  NSRC  per-source enable (mie bits)
- mie  in  1  global interrupt enable
- exc_w  in  1  W-stage instruction raised an exception
- exc_pc  in  64  PC of the excepting W-stage instruction
- stall  in  1  fetch or memory handshake outstanding
- jump  in  1  redirect in flight (branch, mret, csr flush)
- pc_m, pc_e, pc_d, pc_f  in  64 each  stage PCs
- vld_m, vld_e, vld_d  in  1 each  stage holds a non-FLUSH instruction
- trap_ack  in  1  CSR unit has committed mepc/mcause
- trap_o  out  1  one-cycle trap request
- is_exc_o  out  1  trap is an exception (1) or an interrupt (0)
- cause_o  out  $clog2(NSRC)  winning source index; 0 for exceptions
- return_pc_o  out  64  PC to save in mepc
- pending_o  out  NSRC  pending bits (mip view)

## Operation
- Level source: pending[i] = src_i[i] registered every cycle.
- Edge source (macro on): pending[i] set on rising edge of src_i (src_i & ~src_q). Cleared in the cycle the trap for cause i is decided. A new rising edge in that same cycle keeps the bit set.
- eligible = pending & src_en. Winner = lowest set index.
- Blocked = ~mie | stall | jump.
- Return PC for an interrupt: first valid of pc_m (vld_m), pc_e (vld_e), pc_d (vld_d), else pc_f. The PC is sampled in the decision cycle.
- States:
  - IDLE: exc_w → TRAP (exception). Else eligible≠0 and not blocked → TRAP (interrupt). Else eligible≠0 → ARM. Else stay.
  - ARM: exc_w → TRAP (exception). Else eligible=0 → IDLE. Else not blocked → TRAP (interrupt). Else stay.
  - TRAP: trap_o=1 for exactly this cycle → WAIT_ACK.
  - WAIT_ACK: outputs hold is_exc_o, cause_o and return_pc_o. exc_w and eligible are ignored here, but pending bits keep latching. trap_ack → IDLE.
- Exception and interrupt in the same cycle: the exception wins. The interrupt's pending bit is untouched and is re-arbitrated after the ack.

## Timing
- Decision cycle t → trap_o=1 at t+1. All trap outputs are registered.
- trap_o is never high in two consecutive cycles. Minimum spacing between traps is 3 cycles (TRAP, WAIT_ACK with ack, IDLE decision).
- trap_ack arriving in the TRAP cycle is ignored. The ack is only sampled in WAIT_ACK.
- pending_o is registered and lags src_i by one cycle.
- Reset: state IDLE. trap_o, is_exc_o, cause_o, return_pc_o, pending_o, src_q all 0. Reset asserted in any state, including WAIT_ACK, returns to IDLE and discards pending edges.

## Configuration
- IRQ_EDGE_EN defined: EDGE_MASK is honoured, with src_q history and edge-pending clear-on-claim as described above.
- IRQ_EDGE_EN undefined: every source is level-triggered and EDGE_MASK is ignored. No src_q flops are built, and pending mirrors the registered src_i.

## Test plan
- Exception precedence: NSRC=8, mie=1, src_i=8'h04, src_en=8'hFF, exc_w=1, exc_pc=64'h8000_0010 → next cycle trap_o=1, is_exc_o=1, cause_o=0, return_pc_o=64'h8000_0010. After trap_ack, a second trap with cause_o=2, is_exc_o=0.
- Priority and PC pick: src_i=8'h0A, vld_m=0, vld_e=1, pc_e=64'h8000_0100 → trap_o=1, cause_o=1, return_pc_o=64'h8000_0100.
- Blocking: eligible source with mie=0 for 5 cycles, then stall=1 for 3 cycles, then all clear → state stays ARM with no trap_o until the clear cycle, trap_o the cycle after.
- Level deassert in ARM: src_i[3] high 2 cycles with mie=0, then low → return to IDLE, no trap_o ever.
- Edge pending (IRQ_EDGE_EN, EDGE_MASK=8'h01): 1-cycle pulse on src_i[0] while jump=1 → pending_o[0] stays 1. After jump drops, trap_o with cause_o=0, and pending_o[0] clears. A pulse on the claim cycle keeps pending_o[0]=1.
- Reset mid WAIT_ACK: assert reset with no trap_ack → next cycle all outputs 0, state IDLE, pending_o=0.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: trap arbiter between the CSR file (mie/mip) and fetch redirect.
// It latches interrupt sources into pending bits and applies the per-source and global
// enables. It waits for a safe pipeline point, then issues a registered one-cycle trap
// request. Further traps are held off until the CSR unit acknowledges.
// A W-stage exception always beats a pending interrupt.
// Optional feature macro: IRQ_EDGE_EN. When it is defined, EDGE_MASK selects edge-triggered
// sources, which keep src_q history and are cleared when their trap is claimed. When it is
// undefined, every source is level-triggered and no history flops are built.
`timescale 1ns/1ps

module interrupt_arbiter #(
  parameter int              NSRC      = 8,
  parameter logic [NSRC-1:0] EDGE_MASK = '0,
  localparam int             CW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_i,
  input  logic [NSRC-1:0] src_en,
  input  logic            mie,
  input  logic            exc_w,
  input  logic [63:0]     exc_pc,
  input  logic            stall,
  input  logic            jump,
  input  logic [63:0]     pc_m,
  input  logic [63:0]     pc_e,
  input  logic [63:0]     pc_d,
  input  logic [63:0]     pc_f,
  input  logic            vld_m,
  input  logic            vld_e,
  input  logic            vld_d,
  input  logic            trap_ack,
  output logic            trap_o,
  output logic            is_exc_o,
  output logic [CW-1:0]   cause_o,
  output logic [63:0]     return_pc_o,
  output logic [NSRC-1:0] pending_o
);

`ifdef IRQ_EDGE_EN
  localparam logic EDGE_ON = 1'b1;
`else
  localparam logic EDGE_ON = 1'b0;
`endif

  // Effective edge selection: all-zero when the edge feature is compiled out.
  localparam logic [NSRC-1:0] EDGE_BITS = EDGE_MASK & {NSRC{EDGE_ON}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    TRAP     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t          state_reg;
  logic            trap_reg;
  logic            is_exc_reg;
  logic [CW-1:0]   cause_reg;
  logic [63:0]     return_pc_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] pending_next;

  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] claim;
  logic [CW-1:0]   winner;
  logic [63:0]     int_pc;
  logic            blocked;
  logic            arbitrating;
  logic            decide_exc;
  logic            decide_int;

  assign eligible    = pending_reg & src_en;
  // Isolate the lowest set bit: index 0 is the highest priority.
  assign claim       = eligible & (~eligible + NSRC'(1));
  assign blocked     = ~mie | stall | jump;
  assign arbitrating = (state_reg == IDLE) || (state_reg == ARM);
  assign decide_exc  = arbitrating & exc_w;
  assign decide_int  = arbitrating & ~exc_w & (|eligible) & ~blocked;

  // Encode the one-hot claim into the winning source index.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (claim[i]) winner = winner | CW'(i);
    end
  end

  // Interrupt return PC: the oldest in-flight valid instruction, otherwise the fetch PC.
  always_comb begin
    if (vld_m)      int_pc = pc_m;
    else if (vld_e) int_pc = pc_e;
    else if (vld_d) int_pc = pc_d;
    else            int_pc = pc_f;
  end

  // Per-source pending update. Edge sources keep their bit until claimed, and a fresh
  // rising edge in the claim cycle wins over the clear.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      if (EDGE_BITS[gi]) begin : g_edge
        logic src_q_reg;
        // Previous-cycle copy of the raw line for rising-edge detection.
        always_ff @(posedge clk) begin
          if (reset) src_q_reg <= 1'b0;
          else       src_q_reg <= src_i[gi];
        end
        assign pending_next[gi] = (pending_reg[gi] & ~(decide_int & claim[gi]))
                                | (src_i[gi] & ~src_q_reg);
      end else begin : g_level
        assign pending_next[gi] = src_i[gi];
      end
    end
  endgenerate

  // Pending bits (mip view), one cycle behind the raw lines.
  always_ff @(posedge clk) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  // Trap FSM with registered trap outputs, held stable from TRAP through WAIT_ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      trap_reg      <= 1'b0;
      is_exc_reg    <= 1'b0;
      cause_reg     <= '0;
      return_pc_reg <= '0;
    end else begin
      trap_reg <= 1'b0;
      case (state_reg)
        IDLE, ARM: begin
          if (decide_exc) begin
            state_reg     <= TRAP;
            trap_reg      <= 1'b1;
            is_exc_reg    <= 1'b1;
            cause_reg     <= '0;
            return_pc_reg <= exc_pc;
          end else if (decide_int) begin
            state_reg     <= TRAP;
            trap_reg      <= 1'b1;
            is_exc_reg    <= 1'b0;
            cause_reg     <= winner;
            return_pc_reg <= int_pc;
          end else if (|eligible) begin
            state_reg <= ARM;
          end else begin
            state_reg <= IDLE;
          end
        end
        // An ack coinciding with the request pulse is deliberately not sampled.
        TRAP: state_reg <= WAIT_ACK;
        WAIT_ACK: begin
          if (trap_ack) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trap_o      = trap_reg;
  assign is_exc_o    = is_exc_reg;
  assign cause_o     = cause_reg;
  assign return_pc_o = return_pc_reg;
  assign pending_o   = pending_reg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Testbench for interrupt_arbiter: directed vectors with a trap scoreboard.
// Stimulus pushes each expected trap (cycle, kind, cause, return PC) into a queue.
// A negedge monitor pops and compares whenever trap_o is high.
`timescale 1ns/1ps

module tb_interrupt_arbiter;
  localparam int NSRC = 8;
`ifdef IRQ_EDGE_EN
  localparam logic [NSRC-1:0] EDGE_MASK = 8'h01;
`else
  localparam logic [NSRC-1:0] EDGE_MASK = 8'h00;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_i, src_en;
  logic            mie, exc_w, stall, jump, trap_ack;
  logic [63:0]     exc_pc, pc_m, pc_e, pc_d, pc_f;
  logic            vld_m, vld_e, vld_d;
  logic            trap_o, is_exc_o;
  logic [2:0]      cause_o;
  logic [63:0]     return_pc_o;
  logic [NSRC-1:0] pending_o;

  interrupt_arbiter #(.NSRC(NSRC), .EDGE_MASK(EDGE_MASK)) dut (
    .clk(clk), .reset(reset), .src_i(src_i), .src_en(src_en), .mie(mie),
    .exc_w(exc_w), .exc_pc(exc_pc), .stall(stall), .jump(jump),
    .pc_m(pc_m), .pc_e(pc_e), .pc_d(pc_d), .pc_f(pc_f),
    .vld_m(vld_m), .vld_e(vld_e), .vld_d(vld_d), .trap_ack(trap_ack),
    .trap_o(trap_o), .is_exc_o(is_exc_o), .cause_o(cause_o),
    .return_pc_o(return_pc_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        exc;
    logic [2:0]  cause;
    logic [63:0] pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input int at, input logic exc, input logic [2:0] cause, input logic [63:0] pc);
    exp_t e;
    e.cyc = at; e.exc = exc; e.cause = cause; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Monitor: compares every trap pulse against the head of the scoreboard.
  logic prev_trap = 1'b0;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_trap cyc=%0d actual=none required=trap@%0d cause=%0d", cyc, exp_q[0].cyc, exp_q[0].cause);
      void'(exp_q.pop_front());
    end
    if (trap_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trap cyc=%0d actual exc=%0d cause=%0d pc=%h required=no trap", cyc, is_exc_o, cause_o, return_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || is_exc_o !== e.exc || cause_o !== e.cause || return_pc_o !== e.pc || prev_trap) begin
          errors++;
          $display("FAIL trap cyc=%0d actual exc=%0d cause=%0d pc=%h back2back=%0d required cyc=%0d exc=%0d cause=%0d pc=%h",
                   cyc, is_exc_o, cause_o, return_pc_o, prev_trap, e.cyc, e.exc, e.cause, e.pc);
        end else begin
          $display("trap cyc=%0d exc=%0d cause=%0d pc=%h ok", cyc, is_exc_o, cause_o, return_pc_o);
        end
      end
    end
    prev_trap = trap_o;
  end

  initial begin
    int c;
    logic [63:0] exp_pend;
    reset = 1'b1; src_i = '0; src_en = '0; mie = 1'b0; exc_w = 1'b0; stall = 1'b0;
    jump = 1'b0; trap_ack = 1'b0; exc_pc = '0; pc_m = '0; pc_e = '0; pc_d = '0;
    pc_f = '0; vld_m = 1'b0; vld_e = 1'b0; vld_d = 1'b0;
    tick(); tick(); tick();
    check("rst_trap", 64'(trap_o), 64'd0);
    check("rst_is_exc", 64'(is_exc_o), 64'd0);
    check("rst_cause", 64'(cause_o), 64'd0);
    check("rst_pc", return_pc_o, 64'd0);
    check("rst_pending", 64'(pending_o), 64'd0);
    reset = 1'b0;
    tick();

    // Exception beats a simultaneous interrupt; the interrupt follows after ack.
    c = cyc;
    src_en = 8'hFF; mie = 1'b1; src_i = 8'h04; exc_w = 1'b1;
    exc_pc = 64'h8000_0010; pc_f = 64'h8000_0020;
    push(c + 1, 1'b1, 3'd0, 64'h8000_0010);
    wait_to(c + 1); exc_w = 1'b0; trap_ack = 1'b1;
    check("s1_pending", 64'(pending_o), 64'h04);
    wait_to(c + 3); trap_ack = 1'b0;
    push(c + 4, 1'b0, 3'd2, 64'h8000_0020);
    wait_to(c + 4); src_i = '0;
    wait_to(c + 5); trap_ack = 1'b1;
    wait_to(c + 6); trap_ack = 1'b0;
    wait_to(c + 8);

    // Priority (lowest index wins) and return PC from the E stage.
    c = cyc;
    src_i = 8'h0A; vld_m = 1'b0; vld_e = 1'b1; vld_d = 1'b1;
    pc_m = 64'h8000_0200; pc_e = 64'h8000_0100; pc_d = 64'h8000_0300;
    push(c + 2, 1'b0, 3'd1, 64'h8000_0100);
    wait_to(c + 1); check("s2_pending", 64'(pending_o), 64'h0A);
    wait_to(c + 2); src_i = '0;
    wait_to(c + 3); trap_ack = 1'b1;
    wait_to(c + 4); trap_ack = 1'b0;
    wait_to(c + 6);

    // Blocking: mie low 5 cycles, stall 3 cycles, jump 1 cycle, then clear.
    c = cyc;
    mie = 1'b0; src_i = 8'h10; vld_m = 1'b1; pc_m = 64'h8000_0400;
    wait_to(c + 5); mie = 1'b1; stall = 1'b1;
    wait_to(c + 8); stall = 1'b0; jump = 1'b1;
    wait_to(c + 9); jump = 1'b0;
    push(c + 10, 1'b0, 3'd4, 64'h8000_0400);
    wait_to(c + 10); src_i = '0;
    wait_to(c + 11); trap_ack = 1'b1;
    wait_to(c + 12); trap_ack = 1'b0;
    wait_to(c + 14);

    // Level source drops while armed: no trap at all.
    c = cyc;
    mie = 1'b0; src_i = 8'h08; vld_m = 1'b0; vld_e = 1'b0; vld_d = 1'b0;
    wait_to(c + 1); check("s4_pending_hi", 64'(pending_o), 64'h08);
    wait_to(c + 2); src_i = '0;
    wait_to(c + 3); check("s4_pending_lo", 64'(pending_o), 64'h00);
    wait_to(c + 4); mie = 1'b1;
    wait_to(c + 8);

    // Exception while armed; exc_w during WAIT_ACK ignored; interrupt re-arbitrated.
    c = cyc;
    pc_f = 64'h8000_0600; mie = 1'b0; src_i = 8'h20;
    wait_to(c + 2); exc_w = 1'b1; exc_pc = 64'h8000_0500;
    push(c + 3, 1'b1, 3'd0, 64'h8000_0500);
    wait_to(c + 3); exc_w = 1'b0; mie = 1'b1;
    wait_to(c + 4); exc_w = 1'b1; exc_pc = 64'h8000_0580; trap_ack = 1'b1;
    wait_to(c + 5); exc_w = 1'b0; trap_ack = 1'b0;
    push(c + 6, 1'b0, 3'd5, 64'h8000_0600);
    wait_to(c + 6); src_i = '0;
    wait_to(c + 7); trap_ack = 1'b1;
    wait_to(c + 8); trap_ack = 1'b0;
    wait_to(c + 10);

    // Per-source enable masks the higher-priority source.
    c = cyc;
    src_i = 8'h06; src_en = 8'hFD; pc_f = 64'h8000_0700;
    push(c + 2, 1'b0, 3'd2, 64'h8000_0700);
    wait_to(c + 2); src_i = '0;
    wait_to(c + 3); trap_ack = 1'b1;
    wait_to(c + 4); trap_ack = 1'b0; src_en = 8'hFF;
    wait_to(c + 6);

    // Reset while waiting for ack clears everything and returns to IDLE.
    c = cyc;
    src_i = 8'h01; pc_f = 64'h8000_0800;
    push(c + 2, 1'b0, 3'd0, 64'h8000_0800);
    wait_to(c + 3);
    exp_pend = EDGE_MASK[0] ? 64'h00 : 64'h01;
    check("s7_pending_pre", 64'(pending_o), exp_pend);
    reset = 1'b1; src_i = '0;
    wait_to(c + 4); reset = 1'b0;
    check("s7_trap", 64'(trap_o), 64'd0);
    check("s7_is_exc", 64'(is_exc_o), 64'd0);
    check("s7_cause", 64'(cause_o), 64'd0);
    check("s7_pc", return_pc_o, 64'd0);
    check("s7_pending", 64'(pending_o), 64'd0);
    wait_to(c + 5); exc_w = 1'b1; exc_pc = 64'h8000_0900;
    push(c + 6, 1'b1, 3'd0, 64'h8000_0900);
    wait_to(c + 6); exc_w = 1'b0;
    wait_to(c + 7); trap_ack = 1'b1;
    wait_to(c + 8); trap_ack = 1'b0;
    wait_to(c + 10);

`ifdef IRQ_EDGE_EN
    // Edge pulse held while jump blocks, cleared on claim.
    c = cyc;
    jump = 1'b1; src_i = 8'h01; pc_f = 64'h8000_0A00;
    wait_to(c + 1); src_i = '0;
    wait_to(c + 3); check("edge_hold", 64'(pending_o), 64'h01); jump = 1'b0;
    push(c + 4, 1'b0, 3'd0, 64'h8000_0A00);
    wait_to(c + 4); check("edge_clear", 64'(pending_o), 64'h00);
    wait_to(c + 5); trap_ack = 1'b1;
    wait_to(c + 6); trap_ack = 1'b0;
    wait_to(c + 8);
    // A new edge in the claim cycle keeps the bit, so a second trap follows the ack.
    c = cyc;
    jump = 1'b1; src_i = 8'h01;
    wait_to(c + 1); src_i = '0;
    wait_to(c + 2); jump = 1'b0; src_i = 8'h01;
    push(c + 3, 1'b0, 3'd0, 64'h8000_0A00);
    wait_to(c + 3); src_i = '0;
    check("edge_claim_keep", 64'(pending_o), 64'h01);
    wait_to(c + 4); trap_ack = 1'b1;
    wait_to(c + 5); trap_ack = 1'b0;
    push(c + 6, 1'b0, 3'd0, 64'h8000_0A00);
    wait_to(c + 6); check("edge_clear2", 64'(pending_o), 64'h00);
    wait_to(c + 7); trap_ack = 1'b1;
    wait_to(c + 8); trap_ack = 1'b0;
    wait_to(c + 10);
`endif

    wait_to(cyc + 3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
